// File: rtl/lc_pkg.sv
// Shared LEGv8 pipeline definitions: ALU operation codes, the zero-register index
// and the default datapath and register-index widths.
package lc_pkg;

    localparam int unsigned DEF_DATA_W     = 64;
    localparam int unsigned DEF_REG_ADDR_W = 5;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/alu64.sv
// Combinational LEGv8 ALU: (a, b, alu_op) -> (result, zero).
// Add and subtract wrap; codes that are not decoded produce zero.
module alu64
    import lc_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        alu_op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_ORR:   result = a | b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// LEGv8 EX stage: ALU, branch target/decision and the EX/MEM pipeline register.
// Define EX_FORWARDING_EN to forward MEM/WB results onto operands A and B.
module execute_stage
    import lc_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned BR_SHIFT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  RegWrite_EX,
    input  logic                  ALUSrc_EX,
    input  logic                  Branch_EX,
    input  logic                  Uncondbranch_EX,
    input  logic                  MemRead_EX,
    input  logic                  MemWrite_EX,
    input  logic                  Mem2Reg_EX,
    input  logic [3:0]            ALUOp_EX,
    input  logic [REG_ADDR_W-1:0] RD_EX,
    input  logic [REG_ADDR_W-1:0] RN_EX,
    input  logic [REG_ADDR_W-1:0] RM_EX,
    input  logic [DATA_W-1:0]     RegOutA_EX,
    input  logic [DATA_W-1:0]     RegOutB_EX,
    input  logic [DATA_W-1:0]     SignExtImm64_EX,
    input  logic [DATA_W-1:0]     pc_EX,
    input  logic                  RegWrite_WB,
    input  logic [REG_ADDR_W-1:0] RD_WB,
    input  logic [DATA_W-1:0]     MemtoRegOut_WB,
    output logic                  RegWrite_MEM,
    output logic                  MemRead_MEM,
    output logic                  MemWrite_MEM,
    output logic                  Mem2Reg_MEM,
    output logic [REG_ADDR_W-1:0] RD_MEM,
    output logic [DATA_W-1:0]     ALUResult_MEM,
    output logic [DATA_W-1:0]     WriteData_MEM,
    output logic [DATA_W-1:0]     BranchTarget_MEM,
    output logic                  PCSrc_MEM
);

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [DATA_W-1:0] branch_target;
    logic              pcsrc_next;

`ifdef EX_FORWARDING_EN
    localparam logic [REG_ADDR_W-1:0] XZR = REG_ADDR_W'(XZR_IDX);

    logic mem_src_ok;
    logic wb_src_ok;

    // The zero register never produces a value, so it is excluded as a source.
    assign mem_src_ok = RegWrite_MEM && (RD_MEM != XZR);
    assign wb_src_ok  = RegWrite_WB && (RD_WB != XZR);

    always_comb begin
        fwd_a = RegOutA_EX;
        if (mem_src_ok && (RD_MEM == RN_EX))
            fwd_a = ALUResult_MEM;
        else if (wb_src_ok && (RD_WB == RN_EX))
            fwd_a = MemtoRegOut_WB;
    end

    always_comb begin
        fwd_b = RegOutB_EX;
        if (mem_src_ok && (RD_MEM == RM_EX))
            fwd_b = ALUResult_MEM;
        else if (wb_src_ok && (RD_WB == RM_EX))
            fwd_b = MemtoRegOut_WB;
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{RN_EX, RM_EX, RegWrite_WB, RD_WB, MemtoRegOut_WB};
    assign fwd_a      = RegOutA_EX;
    assign fwd_b      = RegOutB_EX;
`endif

    assign alu_b = ALUSrc_EX ? SignExtImm64_EX : fwd_b;

    alu64 #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a      (fwd_a),
        .b      (alu_b),
        .alu_op (ALUOp_EX),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign branch_target = pc_EX + (SignExtImm64_EX << BR_SHIFT);
    assign pcsrc_next    = Uncondbranch_EX | (Branch_EX & alu_zero);

    // A bubble clears data fields too, so reset and flush share one branch.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            RegWrite_MEM     <= 1'b0;
            MemRead_MEM      <= 1'b0;
            MemWrite_MEM     <= 1'b0;
            Mem2Reg_MEM      <= 1'b0;
            RD_MEM           <= '0;
            ALUResult_MEM    <= '0;
            WriteData_MEM    <= '0;
            BranchTarget_MEM <= '0;
            PCSrc_MEM        <= 1'b0;
        end else if (!stall) begin
            RegWrite_MEM     <= RegWrite_EX;
            MemRead_MEM      <= MemRead_EX;
            MemWrite_MEM     <= MemWrite_EX;
            Mem2Reg_MEM      <= Mem2Reg_EX;
            RD_MEM           <= RD_EX;
            ALUResult_MEM    <= alu_result;
            WriteData_MEM    <= fwd_b;
            BranchTarget_MEM <= branch_target;
            PCSrc_MEM        <= pcsrc_next;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: a behavioural model pushes the expected
// EX/MEM contents each cycle; they are popped and compared after the clock edge.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        RegWrite_EX, ALUSrc_EX, Branch_EX, Uncondbranch_EX;
    logic        MemRead_EX, MemWrite_EX, Mem2Reg_EX;
    logic [3:0]  ALUOp_EX;
    logic [4:0]  RD_EX, RN_EX, RM_EX;
    logic [63:0] RegOutA_EX, RegOutB_EX, SignExtImm64_EX, pc_EX;
    logic        RegWrite_WB;
    logic [4:0]  RD_WB;
    logic [63:0] MemtoRegOut_WB;
    logic        RegWrite_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, PCSrc_MEM;
    logic [4:0]  RD_MEM;
    logic [63:0] ALUResult_MEM, WriteData_MEM, BranchTarget_MEM;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct packed {
        logic        rw, mr, mw, m2r, pcs;
        logic [4:0]  rd;
        logic [63:0] res, wd, tgt;
    } exmem_t;

    exmem_t model = '0;
    exmem_t sb[$];

    execute_stage #(
        .DATA_W(64),
        .REG_ADDR_W(5),
        .BR_SHIFT(2)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .RegWrite_EX(RegWrite_EX), .ALUSrc_EX(ALUSrc_EX), .Branch_EX(Branch_EX),
        .Uncondbranch_EX(Uncondbranch_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .Mem2Reg_EX(Mem2Reg_EX), .ALUOp_EX(ALUOp_EX),
        .RD_EX(RD_EX), .RN_EX(RN_EX), .RM_EX(RM_EX),
        .RegOutA_EX(RegOutA_EX), .RegOutB_EX(RegOutB_EX),
        .SignExtImm64_EX(SignExtImm64_EX), .pc_EX(pc_EX),
        .RegWrite_WB(RegWrite_WB), .RD_WB(RD_WB), .MemtoRegOut_WB(MemtoRegOut_WB),
        .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM), .Mem2Reg_MEM(Mem2Reg_MEM), .RD_MEM(RD_MEM),
        .ALUResult_MEM(ALUResult_MEM), .WriteData_MEM(WriteData_MEM),
        .BranchTarget_MEM(BranchTarget_MEM), .PCSrc_MEM(PCSrc_MEM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] fwd_ref(input logic [4:0] idx, input logic [63:0] id_val);
`ifdef EX_FORWARDING_EN
        if (model.rw && model.rd != 5'd31 && model.rd == idx) return model.res;
        if (RegWrite_WB && RD_WB != 5'd31 && RD_WB == idx) return MemtoRegOut_WB;
`endif
        return id_val;
    endfunction

    task automatic clear_in();
        stall = 0; flush = 0;
        RegWrite_EX = 0; ALUSrc_EX = 0; Branch_EX = 0; Uncondbranch_EX = 0;
        MemRead_EX = 0; MemWrite_EX = 0; Mem2Reg_EX = 0; ALUOp_EX = 4'b0010;
        RD_EX = 0; RN_EX = 0; RM_EX = 0;
        RegOutA_EX = 0; RegOutB_EX = 0; SignExtImm64_EX = 0; pc_EX = 0;
        RegWrite_WB = 0; RD_WB = 0; MemtoRegOut_WB = 0;
    endtask

    // Predict the register contents after this edge, then compare after it.
    task automatic step(input string name);
        exmem_t n, e;
        logic [63:0] a, b, opb, r;
        if (reset || flush) begin
            n = '0;
        end else if (stall) begin
            n = model;
        end else begin
            a     = fwd_ref(RN_EX, RegOutA_EX);
            b     = fwd_ref(RM_EX, RegOutB_EX);
            opb   = ALUSrc_EX ? SignExtImm64_EX : b;
            r     = alu_ref(ALUOp_EX, a, opb);
            n.rw  = RegWrite_EX;  n.mr = MemRead_EX; n.mw = MemWrite_EX;
            n.m2r = Mem2Reg_EX;   n.rd = RD_EX;
            n.res = r;            n.wd = b;
            n.tgt = pc_EX + {SignExtImm64_EX[61:0], 2'b00};
            n.pcs = Uncondbranch_EX | (Branch_EX & (r == 64'd0));
        end
        model = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({name, ".RegWrite"}, 64'(RegWrite_MEM), 64'(e.rw));
        check({name, ".MemRead"},  64'(MemRead_MEM),  64'(e.mr));
        check({name, ".MemWrite"}, 64'(MemWrite_MEM), 64'(e.mw));
        check({name, ".Mem2Reg"},  64'(Mem2Reg_MEM),  64'(e.m2r));
        check({name, ".RD"},       64'(RD_MEM),       64'(e.rd));
        check({name, ".ALURes"},   ALUResult_MEM,     e.res);
        check({name, ".WData"},    WriteData_MEM,     e.wd);
        check({name, ".Target"},   BranchTarget_MEM,  e.tgt);
        check({name, ".PCSrc"},    64'(PCSrc_MEM),    64'(e.pcs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        reset = 1;
        step("reset");
        check("reset.ALURes.const", ALUResult_MEM, 64'd0);
        reset = 0;

        // LDUR X9, [A, #8]
        ALUSrc_EX = 1; ALUOp_EX = 4'b0010; RegOutA_EX = 64'h100; SignExtImm64_EX = 64'h8;
        RD_EX = 5'd9; MemRead_EX = 1; Mem2Reg_EX = 1; RegWrite_EX = 1;
        step("ldur");
        check("ldur.ALURes.const", ALUResult_MEM, 64'h108);

        clear_in();
        ALUOp_EX = 4'b0110; RegOutA_EX = 0; RegOutB_EX = 1;
        step("subwrap");
        check("subwrap.const", ALUResult_MEM, 64'hFFFF_FFFF_FFFF_FFFF);
        ALUOp_EX = 4'b1111;
        step("badop");
        RegOutA_EX = 64'hF0F0; RegOutB_EX = 64'hFF00; ALUOp_EX = 4'b0000;
        step("and");
        ALUOp_EX = 4'b0001;
        step("orr");

        // CBZ taken / not taken, then unconditional backward branch
        clear_in();
        Branch_EX = 1; ALUOp_EX = 4'b0111; RegOutB_EX = 0; pc_EX = 64'h40; SignExtImm64_EX = 64'h3;
        step("cbz_taken");
        check("cbz.target.const", BranchTarget_MEM, 64'h4C);
        RegOutB_EX = 5;
        step("cbz_not");
        clear_in();
        Uncondbranch_EX = 1; pc_EX = 64'h40; SignExtImm64_EX = 64'hFFFF_FFFF_FFFF_FFFE;
        step("b_back");
        check("b_back.target.const", BranchTarget_MEM, 64'h38);

        // Stall holds, flush under stall bubbles, reset beats stall
        clear_in();
        RegOutA_EX = 64'h10; RegOutB_EX = 64'h20; RegWrite_EX = 1; MemWrite_EX = 1;
        Uncondbranch_EX = 1; RD_EX = 5'd4;
        step("load30");
        clear_in();
        stall = 1; RegOutA_EX = 64'h5; RegOutB_EX = 64'h5;
        step("stall1");
        step("stall2");
        check("stall.hold.const", ALUResult_MEM, 64'h30);
        flush = 1;
        step("stall_flush");
        clear_in();
        RegOutA_EX = 64'h1; RegOutB_EX = 64'h2; RegWrite_EX = 1;
        step("reload");
        reset = 1; stall = 1;
        step("reset_stall");
        reset = 0; clear_in();

`ifdef EX_FORWARDING_EN
        // ADD X10 -> 0x30 in MEM; WB also targets X10 with 0x99; MEM must win
        RegOutA_EX = 64'h10; RegOutB_EX = 64'h20; RegWrite_EX = 1; RD_EX = 5'd10;
        step("prod10");
        RegWrite_WB = 1; RD_WB = 5'd10; MemtoRegOut_WB = 64'h99;
        RN_EX = 5'd10; RM_EX = 5'd2; RegOutA_EX = 0; RegOutB_EX = 1; RD_EX = 5'd3;
        step("fwd_mem");
        check("fwd_mem.const", ALUResult_MEM, 64'h31);
        clear_in();
        RegOutA_EX = 64'h10; RegOutB_EX = 64'h20; RegWrite_EX = 1; RD_EX = 5'd31;
        step("prod31");
        RegWrite_WB = 1; RD_WB = 5'd31; MemtoRegOut_WB = 64'h99;
        RN_EX = 5'd31; RM_EX = 5'd2; RegOutA_EX = 0; RegOutB_EX = 1;
        step("xzr_nofwd");
        check("xzr_nofwd.const", ALUResult_MEM, 64'h1);
        clear_in();
        step("nop");
        RegWrite_WB = 1; RD_WB = 5'd9; MemtoRegOut_WB = 64'h77; RM_EX = 5'd9; RN_EX = 5'd1;
        ALUSrc_EX = 1; MemWrite_EX = 1; RegOutA_EX = 64'h200; SignExtImm64_EX = 64'h10;
        step("stur_fwd");
        check("stur_fwd.wdata.const", WriteData_MEM, 64'h77);
`else
        // Without forwarding a matching WB producer must be ignored
        RegWrite_WB = 1; RD_WB = 5'd3; MemtoRegOut_WB = 64'h99;
        RN_EX = 5'd3; RM_EX = 5'd3; RegOutA_EX = 64'h7; RegOutB_EX = 64'h1;
        step("nofwd");
        check("nofwd.const", ALUResult_MEM, 64'h8);
`endif

        // Random mix including stalls, flushes and near-colliding register indices
        for (int i = 0; i < 60; i++) begin
            logic [3:0] ops [6];
            ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1011};
            ALUOp_EX        = ops[$urandom_range(0, 5)];
            ALUSrc_EX       = 1'($urandom_range(0, 1));
            RegWrite_EX     = 1'($urandom_range(0, 1));
            MemRead_EX      = 1'($urandom_range(0, 1));
            MemWrite_EX     = 1'($urandom_range(0, 1));
            Mem2Reg_EX      = 1'($urandom_range(0, 1));
            Branch_EX       = 1'($urandom_range(0, 1));
            Uncondbranch_EX = ($urandom_range(0, 7) == 0);
            RD_EX           = 5'($urandom_range(28, 31));
            RN_EX           = 5'($urandom_range(28, 31));
            RM_EX           = 5'($urandom_range(28, 31));
            RD_WB           = 5'($urandom_range(28, 31));
            RegWrite_WB     = 1'($urandom_range(0, 1));
            RegOutA_EX      = {32'($urandom), 32'($urandom)};
            RegOutB_EX      = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
            SignExtImm64_EX = {32'($urandom), 32'($urandom)};
            pc_EX           = {32'($urandom), 32'($urandom)};
            MemtoRegOut_WB  = {32'($urandom), 32'($urandom)};
            stall           = ($urandom_range(0, 5) == 0);
            flush           = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
